multicycle_sequencer: RTL

- Parametrised successor to the core's fixed multi-cycle state controller.
- Adds the UART boot handshake: 0x99 request, size fetch, program fetch, 0xAA acknowledge.
- Adds stall-aware sequencing, configurable fetch/memory wait states, and a retired-instruction counter.
- Sits beside the datapath in the CPU top and drives every pipeline-register, RAM and register-file write enable.

---
 rtl/seq_pkg.sv | 42 ++++
 rtl/seq_wait_counter.sv | 29 ++
 rtl/multicycle_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle sequencer.
//   state_t  : 4-bit explicitly encoded controller state. Encodings 14 and 15
//              are unused and fall back to S_INIT.
//   WAIT_W   : width of the wait-state counter, so wait limits are 1..15.
//   strobe_t : every output of the sequencer, grouped for the state decode.
package seq_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [3:0] {
    S_BOOT_REQ  = 4'd0,
    S_BOOT_SIZE = 4'd1,
    S_BOOT_LOAD = 4'd2,
    S_BOOT_ACK  = 4'd3,
    S_INIT      = 4'd4,
    S_IF        = 4'd5,
    S_IF_ID     = 4'd6,
    S_ID        = 4'd7,
    S_ID_EX     = 4'd8,
    S_EX_MEM    = 4'd9,
    S_MEM       = 4'd10,
    S_MEM_WB    = 4'd11,
    S_WB        = 4'd12,
    S_WB_IF     = 4'd13
  } state_t;

  typedef struct packed {
    logic transmit_0x99;
    logic program_data_size_wren;
    logic program_memory_wren;
    logic transmit_0xaa;
    logic wb_if_wren;
    logic if_id_wren;
    logic id_ex_wren;
    logic ex_mem_wren;
    logic mem_wb_wren;
    logic ram_wren;
    logic reg_wren;
    logic pipeline_register_reset_n;
  } strobe_t;

endpackage

// File: rtl/seq_wait_counter.sv
// Wait-state counter shared by the fetch and memory states.
//   clk    : clock
//   clear  : synchronous clear (reset or any state change), wins over enable
//   enable : count one more wait cycle
//   limit  : number of cycles the current state lasts (1..15)
//   done   : this is the final cycle of the current state
module seq_wait_counter
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              enable,
  input  logic [WAIT_W-1:0] limit,
  output logic              done
);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      wait_cnt <= '0;
    end else if (enable) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign done = (wait_cnt == (limit - WAIT_W'(1)));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle CPU controller: optional UART boot handshake followed by the
// IF .. WB_IF execute loop, driving every pipeline-register, data RAM and
// register-file write enable, plus a retired-instruction counter.
//
// Build option: define SEQ_BOOTLOADER_EN to include the boot states
// (0x99 request, size fetch, program fetch, 0xAA acknowledge). Without it
// reset goes straight to S_INIT, the boot strobes stay 0 and the finished
// inputs are ignored.
//
// Parameters: IF_WAIT (1..15) fetch cycles, MEM_WAIT (1..15) memory cycles,
// CNT_W width of retired_count.
//
// Ports:
//   clk, reset (sync, active-high), stall (freezes execute states only)
//   program_data_size_fetch_finished, program_data_fetch_finished : boot inputs
//   transmit_0x99, program_data_size_wren, program_memory_wren,
//   transmit_0xAA                                   : boot strobes
//   wb_if/if_id/id_ex/ex_mem/mem_wb_wren            : pipeline-register enables
//   ram_wren, reg_wren                              : memory / regfile writes
//   pipeline_register_reset_n                       : active-low pipeline clear
//   retired_count                                   : instructions completed
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int IF_WAIT  = 1,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             program_data_size_fetch_finished,
  input  logic             program_data_fetch_finished,
  output logic             transmit_0x99,
  output logic             program_data_size_wren,
  output logic             program_memory_wren,
  output logic             transmit_0xAA,
  output logic             wb_if_wren,
  output logic             if_id_wren,
  output logic             id_ex_wren,
  output logic             ex_mem_wren,
  output logic             mem_wb_wren,
  output logic             ram_wren,
  output logic             reg_wren,
  output logic             pipeline_register_reset_n,
  output logic [CNT_W-1:0] retired_count
);

`ifdef SEQ_BOOTLOADER_EN
  localparam state_t RESET_STATE = S_BOOT_REQ;
`else
  localparam state_t RESET_STATE = S_INIT;
  logic unused_boot_inputs;
  assign unused_boot_inputs = program_data_size_fetch_finished ^ program_data_fetch_finished;
`endif

  state_t            state;
  state_t            state_nx;
  logic              exec_stall;
  logic              wait_clear;
  logic              wait_en;
  logic              wait_done;
  logic [WAIT_W-1:0] wait_limit;
  strobe_t           strb;

  function automatic logic is_exec(input state_t s);
    return (s >= S_IF) && (s <= S_WB_IF);
  endfunction

  // Stall only freezes the execute loop; boot and init run regardless.
  assign exec_stall = stall && is_exec(state);

  assign wait_limit = (state == S_MEM) ? WAIT_W'(MEM_WAIT) : WAIT_W'(IF_WAIT);
  assign wait_en    = !exec_stall && ((state == S_IF) || (state == S_MEM));
  assign wait_clear = reset || (state_nx != state);

  seq_wait_counter u_wait (
    .clk    (clk),
    .clear  (wait_clear),
    .enable (wait_en),
    .limit  (wait_limit),
    .done   (wait_done)
  );

  always_comb begin
    state_nx = state;
    if (!exec_stall) begin
      case (state)
`ifdef SEQ_BOOTLOADER_EN
        S_BOOT_REQ:  state_nx = S_BOOT_SIZE;
        // Size has priority: the load-finished input is looked at again
        // only once in S_BOOT_LOAD.
        S_BOOT_SIZE: if (program_data_size_fetch_finished) state_nx = S_BOOT_LOAD;
        S_BOOT_LOAD: if (program_data_fetch_finished) state_nx = S_BOOT_ACK;
        S_BOOT_ACK:  state_nx = S_INIT;
`endif
        S_INIT:   state_nx = S_IF;
        S_IF:     if (wait_done) state_nx = S_IF_ID;
        S_IF_ID:  state_nx = S_ID;
        S_ID:     state_nx = S_ID_EX;
        S_ID_EX:  state_nx = S_EX_MEM;
        S_EX_MEM: state_nx = S_MEM;
        S_MEM:    if (wait_done) state_nx = S_MEM_WB;
        S_MEM_WB: state_nx = S_WB;
        S_WB:     state_nx = S_WB_IF;
        S_WB_IF:  state_nx = S_IF;
        default:  state_nx = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RESET_STATE;
      retired_count <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_WB_IF) && !exec_stall) begin
        retired_count <= retired_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    strb = '0;
    strb.pipeline_register_reset_n = 1'b1;
    case (state)
`ifdef SEQ_BOOTLOADER_EN
      S_BOOT_REQ:  strb.transmit_0x99          = 1'b1;
      S_BOOT_SIZE: strb.program_data_size_wren = 1'b1;
      S_BOOT_LOAD: strb.program_memory_wren    = 1'b1;
      S_BOOT_ACK:  strb.transmit_0xaa          = 1'b1;
`endif
      S_INIT:   strb.pipeline_register_reset_n = 1'b0;
      S_IF_ID:  strb.if_id_wren  = 1'b1;
      S_ID_EX:  strb.id_ex_wren  = 1'b1;
      S_EX_MEM: strb.ex_mem_wren = 1'b1;
      // One RAM write per instruction, on the last memory wait cycle.
      S_MEM:    strb.ram_wren    = wait_done;
      S_MEM_WB: strb.mem_wb_wren = 1'b1;
      S_WB:     strb.reg_wren    = 1'b1;
      S_WB_IF:  strb.wb_if_wren  = 1'b1;
      default:  ;
    endcase
    if (exec_stall) begin
      strb = '0;
      strb.pipeline_register_reset_n = 1'b1;
    end
    if (reset) begin
      strb = '0;
    end
  end

  assign transmit_0x99             = strb.transmit_0x99;
  assign program_data_size_wren    = strb.program_data_size_wren;
  assign program_memory_wren       = strb.program_memory_wren;
  assign transmit_0xAA             = strb.transmit_0xaa;
  assign wb_if_wren                = strb.wb_if_wren;
  assign if_id_wren                = strb.if_id_wren;
  assign id_ex_wren                = strb.id_ex_wren;
  assign ex_mem_wren               = strb.ex_mem_wren;
  assign mem_wb_wren               = strb.mem_wb_wren;
  assign ram_wren                  = strb.ram_wren;
  assign reg_wren                  = strb.reg_wren;
  assign pipeline_register_reset_n = strb.pipeline_register_reset_n;

endmodule
